// File: rtl/cga_line_doubler.sv
// cga_line_doubler
//   Scan doubler for CGA video. Each incoming scanline is captured into one of
//   two ping-pong line buffers while the other buffer (the previous line) is
//   replayed twice at the full clk rate, giving a ~31 kHz line rate.
//
// Ports
//   clk          pixel-doubled clock (2x CGA pixel rate)
//   reset_n      asynchronous active-low reset
//   pix_en       input pixel strobe, high one cycle in two
//   video_in     RGBI from the pixel stage, valid when pix_en=1
//   hsync_in     CGA-rate horizontal sync, sampled on pix_en
//   vsync_in     CGA-rate vertical sync, sampled on pix_en
//   video_out    doubled RGBI, blanked while hsync_out is high
//   hsync_out    doubled-rate hsync, active high
//   vsync_out    vsync, changing only at output line starts
//   second_pass  0 = first replay of a line, 1 = second replay
//   overflow     sticky: an input line exceeded the buffer depth
`timescale 1ns/1ps
module cga_line_doubler #(
  parameter int ADDR_W   = 10,
  parameter int HSYNC_W  = 108,
  parameter int MIN_LINE = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pix_en,
  input  logic [3:0] video_in,
  input  logic       hsync_in,
  input  logic       vsync_in,
  output logic [3:0] video_out,
  output logic       hsync_out,
  output logic       vsync_out,
  output logic       second_pass,
  output logic       overflow
);

  localparam int                DEPTH  = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] X_MAX  = '1;
  localparam logic [ADDR_W-1:0] X_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] MIN_X  = ADDR_W'(MIN_LINE);
  localparam logic [ADDR_W-1:0] HS_X   = ADDR_W'(HSYNC_W);

  logic [3:0]        ram_a [DEPTH];
  logic [3:0]        ram_b [DEPTH];

  logic [ADDR_W-1:0] wr_x;
  logic [ADDR_W-1:0] rd_x;
  logic [ADDR_W-1:0] rd_x_d1;
  logic [ADDR_W-1:0] line_len;
  logic              wr_sel;
  logic              hsync_in_q;
  logic              vsync_s;
  logic [3:0]        rd_data;
  logic              line_edge;

  // Rising hsync edge on a strobe cycle, accepted only once the line is long
  // enough; shorter pulses are treated as glitches and ignored.
  always_comb begin
    line_edge = 1'b0;
    if (pix_en && hsync_in && !hsync_in_q && (wr_x >= MIN_X))
      line_edge = 1'b1;
  end

  // Line buffers. wr_sel picks the buffer being filled; the other one is
  // read, so the two sides never touch the same RAM. Contents are not reset.
  always_ff @(posedge clk) begin
    if (pix_en && !wr_sel)
      ram_a[wr_x] <= video_in;
    if (pix_en && wr_sel)
      ram_b[wr_x] <= video_in;
    rd_data <= wr_sel ? ram_a[rd_x] : ram_b[rd_x];
  end

  // Write side. On an accepted edge the edge pixel still lands in the old
  // buffer at the old wr_x; it is excluded from the replay (line_len = wr_x-1).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_x       <= '0;
      wr_sel     <= 1'b0;
      line_len   <= X_MAX;
      hsync_in_q <= 1'b0;
      vsync_s    <= 1'b0;
      overflow   <= 1'b0;
    end else if (pix_en) begin
      hsync_in_q <= hsync_in;
      vsync_s    <= vsync_in;
      if (line_edge) begin
        line_len <= wr_x - X_ONE;
        wr_sel   <= ~wr_sel;
        wr_x     <= '0;
      end else if (wr_x != X_MAX) begin
        wr_x <= wr_x + X_ONE;
        if (wr_x == X_MAX - X_ONE)
          overflow <= 1'b1;
      end
    end
  end

  // Read side: free-runs over the last captured line length; a new line
  // boundary restarts it on the fresh buffer, abandoning the current replay.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_x        <= '0;
      second_pass <= 1'b0;
    end else if (line_edge) begin
      rd_x        <= '0;
      second_pass <= 1'b0;
    end else if (rd_x == line_len) begin
      rd_x        <= '0;
      second_pass <= ~second_pass;
    end else begin
      rd_x <= rd_x + X_ONE;
    end
  end

  // Output stage. rd_x_d1 tracks the address whose RAM data is in rd_data, so
  // sync, blanking and video all line up two cycles after rd_x.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_x_d1   <= '0;
      video_out <= '0;
      hsync_out <= 1'b0;
      vsync_out <= 1'b0;
    end else begin
      rd_x_d1   <= rd_x;
      hsync_out <= (rd_x_d1 < HS_X);
      video_out <= (rd_x_d1 < HS_X) ? 4'h0 : rd_data;
      if (rd_x_d1 == '0)
        vsync_out <= vsync_s;
    end
  end

endmodule

// File: tb/tb_cga_line_doubler.sv
`timescale 1ns/1ps
module tb_cga_line_doubler;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       pix_en = 1'b0;
  logic [3:0] video_in = '0;
  logic       hsync_in = 1'b0;
  logic       vsync_in = 1'b0;
  logic [3:0] video_out;
  logic       hsync_out;
  logic       vsync_out;
  logic       second_pass;
  logic       overflow;

  cga_line_doubler #(.ADDR_W(10), .HSYNC_W(108), .MIN_LINE(16)) dut (
    .clk(clk), .reset_n(reset_n), .pix_en(pix_en), .video_in(video_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .video_out(video_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out),
    .second_pass(second_pass), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct { int rd; bit hs; logic [3:0] vid; bit vcare; } exp_t;
  typedef struct { int npix; int exp_period; bit exp_ovf; } vec_t;

  int         n_pass = 0;
  int         n_total = 0;
  exp_t       sbq[$];
  logic [3:0] cur [1024];
  logic [3:0] rep [1024];
  int         bw, mrd, mlen, since, meas;
  int         lineno = 0;
  bit         hs_prev, msp, mvs_s, mvs_out, movf, rep_valid;
  bit         vs_lvl = 1'b0;

  task automatic check(input string name, input int act, input int req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
  endtask

  task automatic model_reset();
    bw = 0; hs_prev = 0; mrd = 0; mlen = 1023; msp = 0;
    mvs_s = 0; mvs_out = 0; movf = 0; rep_valid = 0;
    since = 0; meas = -1;
    sbq.delete();
    // Output pipeline holds address 0 out of reset: sync high, video blank.
    sbq.push_back('{0, 1'b1, 4'h0, 1'b1});
    sbq.push_back('{0, 1'b1, 4'h0, 1'b1});
  endtask

  // Called at posedge+1ns; outputs must clear as soon as reset_n falls.
  task automatic do_reset();
    #2;
    reset_n = 1'b0; pix_en = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0; vs_lvl = 1'b0;
    #1;
    check("rst_video_out", video_out, 0);
    check("rst_hsync_out", hsync_out, 0);
    check("rst_vsync_out", vsync_out, 0);
    check("rst_second_pass", second_pass, 0);
    check("rst_overflow", overflow, 0);
    repeat (3) @(posedge clk);
    #3 reset_n = 1'b1;
    model_reset();
  endtask

  // One clk cycle: drive, advance the reference model, score the outputs.
  task automatic cyc(input bit pe, input logic [3:0] v, input bit hs, input bit vs);
    exp_t e, o;
    bit   acc;
    pix_en = pe; video_in = v; hsync_in = hs; vsync_in = vs;
    @(posedge clk); #1;
    acc = pe && hs && !hs_prev && (bw >= 16);
    if (pe) cur[bw] = v;
    if (acc) begin
      for (int i = 0; i < 1024; i++) rep[i] = cur[i];
      rep_valid = 1; mlen = bw - 1; mrd = 0; msp = 0; lineno++;
    end else if (mrd == mlen) begin
      mrd = 0; msp = !msp;
    end else begin
      mrd++;
    end
    if (pe) begin
      if (acc) bw = 0;
      else if (bw < 1023) begin
        bw++;
        if (bw == 1023) movf = 1;
      end
      hs_prev = hs;
    end
    e.rd = mrd; e.hs = (mrd < 108);
    e.vid = e.hs ? 4'h0 : rep[mrd];
    e.vcare = e.hs || rep_valid;
    sbq.push_back(e);
    o = sbq.pop_front();
    if (o.rd == 0) mvs_out = mvs_s;
    if (pe) mvs_s = vs;
    check("sb_hsync_out", hsync_out, o.hs);
    if (o.vcare) check("sb_video_out", video_out, o.vid);
    check("sb_vsync_out", vsync_out, mvs_out);
    check("sb_second_pass", second_pass, msp);
    check("sb_overflow", overflow, movf);
    if (acc) begin
      since = 0; meas = -1;
    end else begin
      since++;
      if (meas < 0 && second_pass) meas = since;
    end
  endtask

  task automatic pix(input bit hs);
    logic [3:0] v;
    v = 4'(bw + lineno);
    cyc(1'b1, v, hs, vs_lvl);
    cyc(1'b0, v, hs, vs_lvl);
  endtask

  task automatic line(input int n);
    repeat (n) pix(1'b0);
    pix(1'b1);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 4'h0, 1'b0, vs_lvl);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[5];
    int   guard, w, vnz, prev_hs;
    bit   seen;
    logic [3:0] v;

    // npix before the hsync edge, expected replay period (line_len+1), overflow
    tbl = '{'{20, 20, 1'b0}, '{912, 912, 1'b0}, '{1100, 1023, 1'b1},
            '{600, 600, 1'b1}, '{40, 40, 1'b1}};

    do_reset();

    for (int i = 0; i < 5; i++) begin
      line(tbl[i].npix);
      idle(1100);
      check($sformatf("len_vec%0d_period", i), meas, tbl[i].exp_period);
      check($sformatf("len_vec%0d_overflow", i), overflow, tbl[i].exp_ovf);
    end

    // Steady 912-pixel lines, scored cycle by cycle.
    repeat (3) line(912);

    // hsync pulse width and blanking on a second replay.
    guard = 0;
    while (!(second_pass && !hsync_out) && guard < 3000) begin idle(1); guard++; end
    guard = 0;
    while (!hsync_out && guard < 300) begin idle(1); guard++; end
    w = 0; vnz = 0;
    while (hsync_out && w < 300) begin
      if (video_out != 4'h0) vnz++;
      w++;
      idle(1);
    end
    check("hsync_width", w, 108);
    check("hsync_blank_video", vnz, 0);

    // Glitch pulse after 5 pixels must not end the line.
    repeat (5) pix(1'b0);
    pix(1'b1);
    repeat (294) pix(1'b0);
    pix(1'b1);
    idle(700);
    check("glitch_ignored_period", meas, 300);

    // vsync raised mid-replay: output follows only at the next line start.
    guard = 0;
    while (mrd != 150 && guard < 1000) begin idle(1); guard++; end
    vs_lvl = 1'b1;
    pix(1'b0);
    check("vsync_rise_held", vsync_out, 0);
    seen = 0; guard = 0; prev_hs = hsync_out;
    while (!seen && guard < 700) begin
      idle(1); guard++;
      if (vsync_out) begin
        seen = 1;
        check("vsync_rise_hs_now", hsync_out, 1);
        check("vsync_rise_hs_prev", prev_hs, 0);
      end
      prev_hs = hsync_out;
    end
    check("vsync_rise_seen", seen, 1);
    guard = 0;
    while (mrd != 150 && guard < 1000) begin idle(1); guard++; end
    vs_lvl = 1'b0;
    pix(1'b0);
    check("vsync_fall_held", vsync_out, 1);
    seen = 0; guard = 0; prev_hs = hsync_out;
    while (!seen && guard < 700) begin
      idle(1); guard++;
      if (!vsync_out) begin
        seen = 1;
        check("vsync_fall_hs_now", hsync_out, 1);
        check("vsync_fall_hs_prev", prev_hs, 0);
      end
      prev_hs = hsync_out;
    end
    check("vsync_fall_seen", seen, 1);

    // Hsync edge in the middle of a second replay restarts the read side.
    repeat (910) pix(1'b0);
    pix(1'b1);
    guard = 0;
    while (!(msp && mrd >= 499) && guard < 3000) begin pix(1'b0); guard++; end
    check("restart_pre_second_pass", second_pass, 1);
    v = 4'(bw + lineno);
    cyc(1'b1, v, 1'b1, 1'b0);
    check("restart_second_pass", second_pass, 0);
    check("restart_hs_t1", hsync_out, 0);
    cyc(1'b0, v, 1'b1, 1'b0);
    check("restart_hs_t2", hsync_out, 0);
    cyc(1'b0, v, 1'b0, 1'b0);
    check("restart_hs_new_line", hsync_out, 1);
    repeat (120) pix(1'b0);

    // Reset mid-line at wr_x=300 while outputs are active.
    repeat (180) pix(1'b0);
    check("midline_wr_x", bw, 300);
    guard = 0;
    while (!(video_out != 4'h0 && second_pass) && guard < 3000) begin idle(1); guard++; end
    check("pre_reset_active", (video_out != 4'h0 && second_pass && overflow) ? 1 : 0, 1);
    do_reset();
    idle(1100);
    check("post_reset_rd_wrap", meas, 1024);
    check("post_reset_overflow", overflow, 0);
    line(20);
    idle(100);
    check("post_reset_wr_x_period", meas, 20);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
